cpu_ctrl: RTL and testbench

- Multi-cycle fetch/decode/execute sequencer for the 4-bit CPU.
- Fetches 8-bit instructions from a 16-entry program memory.
- Drives the register file's read selects, write select, write enable and write data, and selects the ALU operation.
- Handles two-word instructions (load-immediate, conditional jump), halt and illegal opcodes.

---
 rtl/cpu_pkg.sv | 20 ++
 rtl/cpu_ctrl_instr_decoder.sv | 25 ++
 rtl/cpu_ctrl.sv | 78 +++++++
 tb/tb_cpu_ctrl.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: opcodes, ALU operation codes and controller states shared by the 4-bit CPU sequencer.
package cpu_pkg;
  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_MOV  = 4'h5;
  localparam logic [3:0] OP_LDI  = 4'h6;
  localparam logic [3:0] OP_JZ   = 4'h7;
  localparam logic [3:0] OP_HALT = 4'hF;
  localparam logic [2:0] ALU_ADD    = 3'd0;
  localparam logic [2:0] ALU_SUB    = 3'd1;
  localparam logic [2:0] ALU_AND    = 3'd2;
  localparam logic [2:0] ALU_OR     = 3'd3;
  localparam logic [2:0] ALU_PASS_B = 3'd4;
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_FETCH2, S_EXEC, S_HALT
  } state_t;
endpackage

// File: rtl/cpu_ctrl_instr_decoder.sv
// instr_decoder: purely combinational classification of the instruction register.
module instr_decoder
  import cpu_pkg::*;
(
  input  logic [7:0] ir,
  output logic [2:0] alu_op,
  output logic       is_write,
  output logic       is_two_word,
  output logic       is_halt,
  output logic       is_illegal
);
  logic [3:0] op;
  assign op = ir[7:4];
  always_comb begin
    alu_op      = op == OP_ADD ? ALU_ADD :
                  op == OP_SUB ? ALU_SUB :
                  op == OP_AND ? ALU_AND :
                  op == OP_OR  ? ALU_OR  :
                  op == OP_MOV ? ALU_PASS_B : ALU_ADD;
    is_write    = op >= OP_ADD && op <= OP_LDI;
    is_two_word = op == OP_LDI || op == OP_JZ;
    is_halt     = op == OP_HALT;
    is_illegal  = op[3] && op != OP_HALT;
  end
endmodule

// File: rtl/cpu_ctrl.sv
// cpu_ctrl: multi-cycle fetch/decode/execute sequencer driving register file and ALU of the 4-bit CPU.
module cpu_ctrl
  import cpu_pkg::*;
#(
  parameter int PC_W   = 4,
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [PC_W-1:0]   instr_addr,
  input  logic [7:0]        instr_data,
  input  logic [DATA_W-1:0] reg_a_data,
  input  logic [DATA_W-1:0] alu_result,
  output logic [1:0]        sel_a,
  output logic [1:0]        sel_b,
  output logic [1:0]        sel_w,
  output logic              write_en,
  output logic [DATA_W-1:0] wb_data,
  output logic [2:0]        alu_op,
  output logic              busy,
  output logic              halted,
  output logic              illegal
);
  state_t state, next;
  logic [PC_W-1:0] pc;
  logic [7:0] ir;
  logic [3:0] imm;
  logic ill_q, go, jz_taken;
  logic is_write, is_two_word, is_halt, is_illegal;
  instr_decoder u_dec (
    .ir(ir), .alu_op(alu_op), .is_write(is_write), .is_two_word(is_two_word),
    .is_halt(is_halt), .is_illegal(is_illegal)
  );
  assign go = start && (state == S_IDLE || state == S_HALT);
  assign jz_taken = state == S_EXEC && ir[7:4] == OP_JZ && reg_a_data == '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_IDLE;
    else state <= next;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pc    <= '0;
      ir    <= '0;
      imm   <= '0;
      ill_q <= 1'b0;
    end else begin
      if (go) pc <= '0;
      else if (state == S_FETCH || state == S_FETCH2) pc <= pc + PC_W'(1);
      else if (jz_taken) pc <= PC_W'(imm);
      if (state == S_FETCH) ir <= instr_data;
      if (state == S_FETCH2) imm <= instr_data[3:0];
      if (go) ill_q <= 1'b0;
      else if (state == S_DECODE && is_illegal) ill_q <= 1'b1;
    end
  always_comb begin
    next = state;
    unique case (state)
      S_IDLE:   next = start ? S_FETCH : S_IDLE;
      S_FETCH:  next = S_DECODE;
      S_DECODE: next = is_halt ? S_HALT : is_two_word ? S_FETCH2 : is_write ? S_EXEC : S_FETCH;
      S_FETCH2: next = S_EXEC;
      S_EXEC:   next = S_FETCH;
      S_HALT:   next = start ? S_FETCH : S_HALT;
      default:  next = S_IDLE;
    endcase
  end
  always_comb begin
    instr_addr = pc;
    sel_a      = ir[3:2];
    sel_b      = ir[1:0];
    sel_w      = ir[3:2];
    write_en   = state == S_EXEC && is_write;
    wb_data    = !write_en ? '0 : is_two_word ? DATA_W'(imm) : alu_result;
    busy       = state != S_IDLE && state != S_HALT;
    halted     = state == S_HALT;
    illegal    = ill_q;
  end
endmodule

// File: tb/tb_cpu_ctrl.sv
// tb_cpu_ctrl: table-driven single-instruction vectors plus hand sequences, with a write scoreboard.
module tb_cpu_ctrl;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [3:0] instr_addr, reg_a_data, alu_result, wb_data;
  logic [7:0] instr_data;
  logic [1:0] sel_a, sel_b, sel_w;
  logic [2:0] alu_op;
  logic write_en, busy, halted, illegal;
  logic [7:0] mem [16];
  logic [3:0] rf [4];
  logic pre_en = 1'b0;
  logic [15:0] pre_val = '0;
  int errors = 0, checks = 0;
  typedef struct { logic [1:0] sel; logic [3:0] wb; logic [2:0] op; } wr_t;
  typedef struct {
    logic [7:0] w0, w1; logic [15:0] rfv; int lat; logic [3:0] addr;
    logic we; logic [1:0] sel; logic [3:0] wb; logic [2:0] op; logic ill;
  } vec_t;
  wr_t q[$];
  vec_t vecs[11];
  always #5 clk = ~clk;
  cpu_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .instr_addr(instr_addr), .instr_data(instr_data),
    .reg_a_data(reg_a_data), .alu_result(alu_result), .sel_a(sel_a), .sel_b(sel_b), .sel_w(sel_w),
    .write_en(write_en), .wb_data(wb_data), .alu_op(alu_op), .busy(busy), .halted(halted),
    .illegal(illegal)
  );
  assign instr_data = mem[instr_addr];
  assign reg_a_data = rf[sel_a];
  assign alu_result = alu_op == 3'd0 ? rf[sel_a] + rf[sel_b] :
                      alu_op == 3'd1 ? rf[sel_a] - rf[sel_b] :
                      alu_op == 3'd2 ? rf[sel_a] & rf[sel_b] :
                      alu_op == 3'd3 ? rf[sel_a] | rf[sel_b] : rf[sel_b];
  always @(posedge clk)
    if (pre_en) for (int i = 0; i < 4; i++) rf[i] <= pre_val[4*i +: 4];
    else if (write_en) rf[sel_w] <= wb_data;
  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick();
    wr_t e;
    @(negedge clk);
    if (rst_n && write_en) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got sel_w=%0d wb=%0h expected no write", sel_w, wb_data);
      end else begin
        e = q.pop_front();
        if ({sel_w, wb_data, alu_op} !== {e.sel, e.wb, e.op}) begin
          errors++;
          $display("FAIL write: got sel_w=%0d wb=%0h op=%0d expected sel_w=%0d wb=%0h op=%0d",
                   sel_w, wb_data, alu_op, e.sel, e.wb, e.op);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask
  task automatic clear_mem();
    for (int i = 0; i < 16; i++) mem[i] = 8'hF0;
  endtask
  task automatic preload(logic [15:0] v);
    pre_val = v;
    pre_en = 1'b1;
    tick();
    pre_en = 1'b0;
  endtask
  task automatic go();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask
  task automatic push(logic [1:0] sel, logic [3:0] wb, logic [2:0] op);
    q.push_back('{sel, wb, op});
  endtask
  task automatic drain(string name);
    check(name, q.size(), 0);
    q.delete();
  endtask
  task automatic wait_halt(int n, string name);
    int k = 0;
    while (!halted && k < n) begin
      tick();
      k++;
    end
    check(name, halted, 1);
  endtask
  initial begin
    vecs[0]  = '{8'h64, 8'h05, 16'h0000, 4, 4'd2, 1'b1, 2'd1, 4'h5, 3'd0, 1'b0};
    vecs[1]  = '{8'h11, 8'hF0, 16'h0043, 3, 4'd1, 1'b1, 2'd0, 4'h7, 3'd0, 1'b0};
    vecs[2]  = '{8'h21, 8'hF0, 16'h0043, 3, 4'd1, 1'b1, 2'd0, 4'hF, 3'd1, 1'b0};
    vecs[3]  = '{8'h3B, 8'hF0, 16'hAC00, 3, 4'd1, 1'b1, 2'd2, 4'h8, 3'd2, 1'b0};
    vecs[4]  = '{8'h4B, 8'hF0, 16'hAC00, 3, 4'd1, 1'b1, 2'd2, 4'hE, 3'd3, 1'b0};
    vecs[5]  = '{8'h56, 8'hF0, 16'h0900, 3, 4'd1, 1'b1, 2'd1, 4'h9, 3'd4, 1'b0};
    vecs[6]  = '{8'h78, 8'h09, 16'h0000, 4, 4'd9, 1'b0, 2'd0, 4'h0, 3'd0, 1'b0};
    vecs[7]  = '{8'h78, 8'h09, 16'h0100, 4, 4'd2, 1'b0, 2'd0, 4'h0, 3'd0, 1'b0};
    vecs[8]  = '{8'h00, 8'hF0, 16'h0000, 2, 4'd1, 1'b0, 2'd0, 4'h0, 3'd0, 1'b0};
    vecs[9]  = '{8'h80, 8'hF0, 16'h0000, 2, 4'd1, 1'b0, 2'd0, 4'h0, 3'd0, 1'b1};
    vecs[10] = '{8'hE5, 8'hF0, 16'h0000, 2, 4'd1, 1'b0, 2'd0, 4'h0, 3'd0, 1'b1};
    clear_mem();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      check("idle_outputs", {instr_addr, sel_a, sel_b, sel_w, write_en, wb_data, alu_op,
                             busy, halted, illegal}, 0);
      tick();
    end
    foreach (vecs[i]) begin
      do_reset();
      clear_mem();
      mem[0] = vecs[i].w0;
      mem[1] = vecs[i].w1;
      preload(vecs[i].rfv);
      if (vecs[i].we) push(vecs[i].sel, vecs[i].wb, vecs[i].op);
      go();
      repeat (vecs[i].lat) tick();
      check($sformatf("vec%0d_addr", i), instr_addr, vecs[i].addr);
      check($sformatf("vec%0d_status", i), {busy, halted, illegal}, {2'b10, vecs[i].ill});
      drain($sformatf("vec%0d_pending", i));
    end
    for (int s = 0; s < 2; s++) begin
      do_reset();
      clear_mem();
      mem[0] = 8'h60; mem[1] = 8'h03; mem[2] = 8'h64; mem[3] = 8'h04;
      mem[4] = s == 0 ? 8'h11 : 8'h21;
      push(2'd0, 4'h3, 3'd0);
      push(2'd1, 4'h4, 3'd0);
      push(2'd0, s == 0 ? 4'h7 : 4'hF, s == 0 ? 3'd0 : 3'd1);
      go();
      wait_halt(40, "prog_halt");
      check(s == 0 ? "prog_add_r0" : "prog_sub_r0", rf[0], s == 0 ? 4'h7 : 4'hF);
      drain("prog_pending");
    end
    do_reset();
    clear_mem();
    mem[0] = 8'h80;
    go();
    wait_halt(10, "halt_reached");
    check("halt_illegal_set", illegal, 1);
    for (int i = 0; i < 10; i++) begin
      check("halt_frozen", {instr_addr, halted, busy}, {4'd2, 2'b10});
      tick();
    end
    go();
    check("restart", {instr_addr, halted, illegal, busy}, {4'd0, 3'b001});
    tick();
    go();
    check("start_while_busy", {instr_addr, busy}, {4'd1, 1'b1});
    wait_halt(10, "halt_again");
    do_reset();
    clear_mem();
    mem[0] = 8'h64; mem[1] = 8'h05;
    preload(16'h00A0);
    go();
    repeat (3) tick();
    check("exec_we", write_en, 1);
    rst_n = 1'b0;
    #1;
    check("reset_we_drop", write_en, 0);
    tick();
    rst_n = 1'b1;
    check("reset_no_write", rf[1], 4'hA);
    check("reset_addr", instr_addr, 0);
    drain("reset_pending");
    do_reset();
    clear_mem();
    mem[0] = 8'h0C;
    for (int i = 1; i < 15; i++) mem[i] = 8'h00;
    mem[15] = 8'h67;
    push(2'd1, 4'hC, 3'd0);
    go();
    repeat (34) tick();
    check("wrap_addr", instr_addr, 1);
    check("wrap_r1", rf[1], 4'hC);
    drain("wrap_pending");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
